// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU; registers the result and returns it
// to the granted port over a per-port valid/ready response channel, one op outstanding.
module alu_share_arbiter #(
   parameter bit RR_EN = 1'b1,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [4:0]   req_op0,
   input  logic [4:0]   req_op1,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_b1,
   input  logic [4:0]   req_sh0,
   input  logic [4:0]   req_sh1,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [4:0]   alu_op,
   output logic [4:0]   alu_shamt,
   input  logic [W-1:0] alu_c,
   input  logic         alu_zero,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_zero,
   input  logic         flush,
   output logic         busy
);

   // ALUOp encoding shared with the ALU
   localparam logic [4:0] ALUOP_ADDU = 5'b00000;
   localparam logic [4:0] ALUOP_BEQ  = 5'b01000;
   localparam logic [4:0] ALUOP_BNE  = 5'b01001;

   typedef enum logic {IDLE, RESP} state_t;

   // Handshakes: a request moves when req_valid[p] & req_ready[p] on a rising edge;
   // a response moves when rsp_valid[p] & rsp_ready[p]. Requesters never wait on ready.
   state_t         state_q, state_d;
   logic           owner_q;
   logic           last_q;
   logic [W-1:0]   rsp_data_q;
   logic           rsp_zero_q;
   logic           grant;
   logic           gsel;
   logic           is_branch;

   always_comb begin
      grant   = 1'b0;
      gsel    = 1'b0;
      state_d = state_q;
      if (!flush && (|req_valid) && (state_q == IDLE || rsp_ready[owner_q]))
         grant = 1'b1;
      if (req_valid == 2'b11)
         gsel = RR_EN ? ~last_q : 1'b0;
      else
         gsel = req_valid[1];
      if (flush)
         state_d = IDLE;
      else if (grant)
         state_d = RESP;
      else if (state_q == RESP && rsp_ready[owner_q])
         state_d = IDLE;
   end

   always_comb begin
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = ALUOP_ADDU;
      alu_shamt = '0;
      req_ready = 2'b00;
      if (grant) begin
         req_ready = gsel ? 2'b10 : 2'b01;
         alu_a     = gsel ? req_a1  : req_a0;
         alu_b     = gsel ? req_b1  : req_b0;
         alu_op    = gsel ? req_op1 : req_op0;
         alu_shamt = gsel ? req_sh1 : req_sh0;
      end
   end

   assign is_branch = (alu_op == ALUOP_BEQ) || (alu_op == ALUOP_BNE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            rsp_data_q <= alu_c;
            rsp_zero_q <= is_branch ? alu_zero : 1'b0;
            owner_q    <= gsel;
            last_q     <= gsel;
         end
      end
   end

   assign busy      = (state_q == RESP);
   assign rsp_valid = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus, each driven by its own behavioural ALU.
module tb_alu_share_arbiter;

   localparam int W = 32;
   localparam logic [4:0] OP_ADDU = 5'b00000;
   localparam logic [4:0] OP_SUBU = 5'b00001;
   localparam logic [4:0] OP_SLL  = 5'b00100;
   localparam logic [4:0] OP_BEQ  = 5'b01000;
   localparam logic [4:0] OP_BNE  = 5'b01001;

   logic         clk = 1'b0;
   logic         rstn;
   logic [1:0]   req_valid;
   logic [4:0]   req_op0, req_op1, req_sh0, req_sh1;
   logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
   logic [1:0]   rsp_ready;
   logic         flush;

   logic [1:0]   rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
   logic [W-1:0] rr_alu_a, rr_alu_b, rr_alu_c, rr_rsp_data;
   logic [W-1:0] fp_alu_a, fp_alu_b, fp_alu_c, fp_rsp_data;
   logic [4:0]   rr_alu_op, rr_alu_shamt, fp_alu_op, fp_alu_shamt;
   logic         rr_alu_zero, rr_rsp_zero, rr_busy;
   logic         fp_alu_zero, fp_rsp_zero, fp_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.RR_EN(1'b1), .W(W)) dut_rr (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rr_req_ready),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1), .req_sh0(req_sh0), .req_sh1(req_sh1),
      .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op), .alu_shamt(rr_alu_shamt),
      .alu_c(rr_alu_c), .alu_zero(rr_alu_zero), .rsp_valid(rr_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rr_rsp_data), .rsp_zero(rr_rsp_zero),
      .flush(flush), .busy(rr_busy)
   );

   alu_share_arbiter #(.RR_EN(1'b0), .W(W)) dut_fp (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(fp_req_ready),
      .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1), .req_sh0(req_sh0), .req_sh1(req_sh1),
      .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op), .alu_shamt(fp_alu_shamt),
      .alu_c(fp_alu_c), .alu_zero(fp_alu_zero), .rsp_valid(fp_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_zero(fp_rsp_zero),
      .flush(flush), .busy(fp_busy)
   );

   // Behavioural ALU: BNE raises Zero when the operands differ (branch taken)
   function automatic logic [W:0] alu_f(input logic [4:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [4:0] sh);
      logic [W-1:0] c;
      logic         z;
      case (op)
         OP_SUBU: c = a - b;
         OP_SLL:  c = b << sh;
         OP_BEQ:  c = a - b;
         OP_BNE:  c = a - b;
         default: c = a + b;
      endcase
      z = (op == OP_BNE) ? (a != b) : (c == '0);
      return {z, c};
   endfunction

   always_comb {rr_alu_zero, rr_alu_c} = alu_f(rr_alu_op, rr_alu_a, rr_alu_b, rr_alu_shamt);
   always_comb {fp_alu_zero, fp_alu_c} = alu_f(fp_alu_op, fp_alu_a, fp_alu_b, fp_alu_shamt);

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req_valid = 2'b00; rsp_ready = 2'b00; flush = 1'b0;
      req_op0 = OP_ADDU; req_op1 = OP_ADDU; req_sh0 = '0; req_sh1 = '0;
      req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
      tick(); tick();
      rstn = 1'b1;
      #1;
   endtask

   task automatic set_p0(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh);
      req_op0 = op; req_a0 = a; req_b0 = b; req_sh0 = sh;
   endtask

   task automatic set_p1(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh);
      req_op1 = op; req_a1 = a; req_b1 = b; req_sh1 = sh;
   endtask

   initial begin
      // reset state and idle ALU drive
      do_reset();
      chk("rst_rsp_valid", rr_rsp_valid, 2'b00);
      chk("rst_rsp_data", rr_rsp_data, 0);
      chk("rst_rsp_zero", rr_rsp_zero, 0);
      chk("rst_req_ready", rr_req_ready, 2'b00);
      chk("rst_busy", rr_busy, 0);
      chk("idle_alu_a", rr_alu_a, 0);
      chk("idle_alu_op", rr_alu_op, OP_ADDU);

      // single request
      rsp_ready = 2'b11;
      set_p0(OP_ADDU, 5, 7, 0);
      req_valid = 2'b01;
      #1;
      chk("single_req_ready", rr_req_ready, 2'b01);
      chk("single_alu_a", rr_alu_a, 5);
      chk("single_alu_b", rr_alu_b, 7);
      tick();
      req_valid = 2'b00;
      #1;
      chk("single_rsp_valid", rr_rsp_valid, 2'b01);
      chk("single_rsp_data", rr_rsp_data, 12);
      chk("single_busy", rr_busy, 1);
      tick();
      chk("single_back_idle", rr_rsp_valid, 2'b00);
      chk("single_busy_low", rr_busy, 0);

      // round-robin contention
      do_reset();
      rsp_ready = 2'b11;
      set_p0(OP_ADDU, 5, 7, 0);
      set_p1(OP_SUBU, 10, 3, 0);
      req_valid = 2'b11;
      #1;
      chk("rr_grant0", rr_req_ready, 2'b01);
      tick();
      chk("rr_grant1", rr_req_ready, 2'b10);
      chk("rr_rsp0_valid", rr_rsp_valid, 2'b01);
      chk("rr_rsp0_data", rr_rsp_data, 12);
      tick();
      chk("rr_grant2", rr_req_ready, 2'b01);
      chk("rr_rsp1_valid", rr_rsp_valid, 2'b10);
      chk("rr_rsp1_data", rr_rsp_data, 7);
      tick();
      chk("rr_grant3", rr_req_ready, 2'b10);
      chk("rr_rsp2_valid", rr_rsp_valid, 2'b01);

      // fixed priority instance
      do_reset();
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fp_p0_wins_%0d", i), fp_req_ready, 2'b01);
         tick();
      end
      req_valid = 2'b10;
      #1;
      chk("fp_p1_after_drop", fp_req_ready, 2'b10);
      tick();
      chk("fp_p1_rsp_valid", fp_rsp_valid, 2'b10);

      // backpressure on port 0 with port 1 waiting
      do_reset();
      rsp_ready = 2'b00;
      set_p0(OP_ADDU, 5, 7, 0);
      set_p1(OP_SUBU, 10, 3, 0);
      req_valid = 2'b01;
      #1;
      chk("bp_grant0", rr_req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_data_%0d", i), rr_rsp_data, 12);
         chk($sformatf("bp_busy_%0d", i), rr_busy, 1);
         chk($sformatf("bp_req_ready_%0d", i), rr_req_ready, 2'b00);
         chk($sformatf("bp_rsp_valid_%0d", i), rr_rsp_valid, 2'b01);
         tick();
      end
      rsp_ready = 2'b01;
      #1;
      chk("bp_release_grant1", rr_req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      #1;
      chk("bp_p1_rsp_valid", rr_rsp_valid, 2'b10);
      chk("bp_p1_rsp_data", rr_rsp_data, 7);

      // branch flag
      do_reset();
      rsp_ready = 2'b11;
      set_p0(OP_BEQ, 9, 9, 0);
      req_valid = 2'b01;
      tick();
      chk("beq_zero", rr_rsp_zero, 1);
      set_p0(OP_BNE, 9, 9, 0);
      #1;
      chk("bne_grant", rr_req_ready, 2'b01);
      tick();
      chk("bne_zero", rr_rsp_zero, 0);
      set_p0(OP_SLL, 0, 1, 4);
      tick();
      chk("sll_data", rr_rsp_data, 16);
      chk("sll_zero", rr_rsp_zero, 0);
      set_p0(OP_ADDU, 0, 0, 0);
      tick();
      chk("addu_zero_masked", rr_rsp_zero, 0);
      chk("addu_zero_data", rr_rsp_data, 0);
      req_valid = 2'b00;

      // flush in RESP
      do_reset();
      rsp_ready = 2'b00;
      set_p0(OP_ADDU, 5, 7, 0);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10;
      rsp_ready = 2'b01;
      flush = 1'b1;
      #1;
      chk("flush_no_grant", rr_req_ready, 2'b00);
      tick();
      flush = 1'b0;
      req_valid = 2'b00;
      #1;
      chk("flush_rsp_valid", rr_rsp_valid, 2'b00);
      chk("flush_busy", rr_busy, 0);
      chk("flush_stale_data", rr_rsp_data, 12);

      // async reset mid-RESP, then first contention goes to port 0
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      #1;
      chk("pre_rst_busy", rr_busy, 1);
      rstn = 1'b0;
      #1;
      chk("async_rst_rsp_valid", rr_rsp_valid, 2'b00);
      chk("async_rst_rsp_data", rr_rsp_data, 0);
      #2;
      rstn = 1'b1;
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      #1;
      chk("post_rst_port0_wins", rr_req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters: port 0 is the main pipeline execute stage, port 1 is an auxiliary unit such as address generation or a multicycle helper.
- Arbitrates requests, drives the ALU operand, op and shamt inputs, and registers the ALU result.
- Returns the registered result to the granted requester over a valid/ready response channel.
- At most one operation is outstanding at any time.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- W, 32, operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit p belongs to port p.
- req_ready  out  2  per-port request accepted this cycle; combinational and one-hot or zero.
- req_op0, req_op1  in  5 each  ALU opcode per port; same 5-bit ALUOp encoding as the ALU.
- req_a0, req_a1  in  W each  operand A per port.
- req_b0, req_b1  in  W each  operand B per port.
- req_sh0, req_sh1  in  5 each  shift amount per port.
- alu_a  out  W  to ALU input A.
- alu_b  out  W  to ALU input B.
- alu_op  out  5  to ALU opcode input.
- alu_shamt  out  5  to ALU shamt input.
- alu_c  in  W  ALU result.
- alu_zero  in  1  ALU Zero flag.
- rsp_valid  out  2  per-port response valid; one-hot or zero.
- rsp_ready  in  2  per-port response accept.
- rsp_data  out  W  registered result, shared by both ports.
- rsp_zero  out  1  registered branch flag.
- flush  in  1  synchronous cancel of the outstanding response.
- busy  out  1  high when a response is held (state RESP).

Behaviour:
- Reset (async, rstn=0):
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_zero = 0; req_ready = 0.
  - last_grant = 1, so port 0 wins the first contention.
- ALU drive:
  - When a grant is issued, alu_a/alu_b/alu_op/alu_shamt equal the granted port's fields in the same cycle (combinational mux).
  - With no grant, ALU inputs are 0 and alu_op = ALUOp_ADDU, so there is no spurious Zero update.
- Grant condition: grant allowed in a cycle iff flush=0 AND any req_valid AND (state=IDLE OR (state=RESP AND rsp_ready[owner]=1)).
- Arbitration:
  - Only one requesting port: that port wins.
  - Both requesting, RR_EN=1: the port other than last_grant wins.
  - Both requesting, RR_EN=0: port 0 wins.
  - last_grant updates only on an actual grant.
- Handshake:
  - req_ready[p] = grant to p. A request transfers when req_valid[p] & req_ready[p].
  - Requesters hold valid and fields stable until accepted; no ready-to-valid dependency on the requester side.
- Capture on the grant edge:
  - rsp_data <= alu_c.
  - rsp_zero <= alu_zero if op is ALUOp_BEQ or ALUOp_BNE, else 0.
  - owner <= granted port; state <= RESP.
  - Latency: response is valid exactly 1 cycle after acceptance.
- State machine, IDLE:
  - Grant -> RESP.
  - Otherwise stay IDLE.
- State machine, RESP:
  - rsp_valid[owner] = 1; rsp_data/rsp_zero held stable.
  - rsp_ready[owner]=1 with a new grant -> stay RESP with the new result (back-to-back, 1 op/cycle).
  - rsp_ready[owner]=1 with no grant -> IDLE.
  - rsp_ready[owner]=0 -> hold; no grant; both req_ready = 0.
  - rsp_ready of the non-owner port is ignored.
- Flush:
  - Next state is IDLE and rsp_valid clears next cycle.
  - No grant in the flush cycle, even if requests are pending.
  - rsp_data keeps its stale value.
  - Flush takes precedence over rsp_ready and req_valid.
- Arithmetic: none internal; width is W throughout; no truncation.
- Reset mid-operation: the pending response is discarded immediately (async) and the request is not replayed.
- busy = (state == RESP).

Test Plan:
- Single request: port 0 sends ADDU a=5 b=7 with rsp_ready=1. Expected: req_ready[0]=1 in cycle 0, then rsp_valid=2'b01 with rsp_data=12 in cycle 1, then IDLE.
- Contention with RR_EN=1: both ports valid every cycle with rsp_ready=11. Expected grant order 0,1,0,1; port 1 SUBU 10-3 returns 7 with rsp_valid=2'b10.
- Fixed priority with RR_EN=0: both ports continuously valid. Expected: port 1 never granted; port 1 is granted only after port 0 valid drops.
- Backpressure: port 0 response with rsp_ready[0]=0 for 3 cycles while port 1 is valid. Expected: rsp_data stable, busy=1, req_ready=00 throughout; port 1 is granted in the same cycle rsp_ready[0] rises.
- Branch flag: BEQ a=b=9 gives rsp_zero=1; BNE a=b=9 gives rsp_zero=0; SLL b=1 shamt=4 gives rsp_data=16 with rsp_zero=0.
- Flush and reset: flush asserted in RESP drops rsp_valid to 00 next cycle with no grant that cycle. rstn pulled low mid-RESP clears rsp_valid/rsp_data asynchronously; after release, port 0 wins the first contention.
